// File: rtl/serial_add_pkg.sv
// Shared encodings for the serial-add scheduler slice.
// Pure declarations: no latency, no flow control.
// State and requester-ID constants used by the top and the bench.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: A/B/sum shift registers plus carry flop.
// Latency: one sum bit per shift_en cycle, LSB first; full sum after WIDTH shifts.
// Backpressure: none, the sequencer alone decides when to load and shift.
module serial_add_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             s_bit;
    logic             c_nxt;

    assign s_bit = a_sh[0] ^ b_sh[0] ^ cout;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & cout) | (b_sh[0] & cout);

    // sum is left untouched by load so the previous result stays readable until shifting starts
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            a_sh <= a_in;
            b_sh <= b_in;
            cout <= 1'b0;
        end else if (shift_en) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            sum  <= {s_bit, sum[WIDTH-1:1]};
            cout <= c_nxt;
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin sequencer sharing one bit-serial adder between two requesters.
// Latency: accept in cycle T -> rsp_valid in cycle T+WIDTH+1; one op per WIDTH+2 cycles.
// Backpressure: holds the result in DONE until rsp_ready; no requester is readied outside IDLE.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic             rr_ptr;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             gnt_id;
    logic             in_idle;
    logic [WIDTH-1:0] ld_a;
    logic [WIDTH-1:0] ld_b;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic [WIDTH-1:0] sum_hold;
    logic             cout_hold;

    assign in_idle = (state == ST_IDLE) && !reset;
    assign grant0  = in_idle && req0_valid && (!req1_valid || (rr_ptr == REQ0));
    assign grant1  = in_idle && req1_valid && (!req0_valid || (rr_ptr == REQ1));
    assign accept  = grant0 | grant1;
    assign gnt_id  = grant1 ? REQ1 : REQ0;
    assign ld_a    = grant1 ? req1_a : req0_a;
    assign ld_b    = grant1 ? req1_b : req0_b;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    serial_add_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift_en (state == ST_SHIFT),
        .a_in     (ld_a),
        .b_in     (ld_b),
        .sum      (core_sum),
        .cout     (core_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            rr_ptr    <= REQ0;
            rsp_id    <= REQ0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        count  <= '0;
                        rsp_id <= gnt_id;
                        rr_ptr <= ~gnt_id;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (count == LAST) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // The core's sum/carry churn while shifting; show the last finished result instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_hold  <= '0;
            cout_hold <= 1'b0;
        end else if (state != ST_SHIFT) begin
            sum_hold  <= core_sum;
            cout_hold <= core_cout;
        end
    end

    assign rsp_sum  = (state == ST_SHIFT) ? sum_hold  : core_sum;
    assign rsp_cout = (state == ST_SHIFT) ? cout_hold : core_cout;

endmodule
